obi_data_responder: RTL

// - OBI data-bus responder (memory end) for the CPU/RTOSUnit arbitrated data port in simulation wrappers.
// - Accepts req/gnt transactions, applies byte-enabled writes to a word array, returns in-order rvalid/rdata.
// - Configurable response latency, outstanding-transaction limit and bench-driven grant/response stalls.
// - Exercises the initiator's request-source tracking under pipelined and back-pressured traffic.

---
 rtl/obi_data_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/obi_data_responder.sv
// OBI data-bus responder: byte-enabled word memory behind an in-order response queue
// with configurable latency, outstanding limit and externally forced grant/response stalls.

module obi_data_responder_chk #(
  parameter int RESP_LAT  = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(MAX_OUTST):0] outst_i,
  input  logic                       pop_i,
  input  logic                       empty_i
);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  lat_min_a:   assert property (@(posedge clk_i) disable iff (rst_i) RESP_LAT >= 1);
  outst_max_a: assert property (@(posedge clk_i) disable iff (rst_i) outst_i <= CNT_W'(MAX_OUTST));
  pop_empty_a: assert property (@(posedge clk_i) disable iff (rst_i) pop_i |-> !empty_i);
endmodule

module obi_data_responder #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 16384,
  parameter int RESP_LAT  = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  output logic                       gnt_o,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       we_i,
  input  logic [3:0]                 be_i,
  input  logic [31:0]                wdata_i,
  output logic                       rvalid_o,
  output logic [31:0]                rdata_o,
  output logic                       err_o,
  input  logic                       gnt_stall_i,
  input  logic                       resp_stall_i,
  output logic [$clog2(MAX_OUTST):0] outst_o
);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTST) + 1;
  localparam int AGE_W  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTST - 1);
  // Age counts edges survived after the accept edge, so the popping edge is the RESP_LAT-th one.
  localparam logic [AGE_W-1:0] AGE_RDY   = AGE_W'(RESP_LAT - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [31:0]      mem_r    [DEPTH];
  logic [31:0]      q_data_r [MAX_OUTST];
  logic             q_err_r  [MAX_OUTST];
  logic [AGE_W-1:0] q_age_r  [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] outst_r;
  logic             rvalid_r;
  logic [31:0]      rdata_r;
  logic             err_r;

  logic [IDX_W-1:0]  word_idx_s;
  logic [MEM_AW-1:0] mem_idx_s;
  logic              in_range_s;
  logic              accept_s;
  logic              empty_s;
  logic              head_rdy_s;
  logic              pop_s;
  logic [31:0]       push_data_s;
  logic              push_err_s;
  logic              unused_s;

  assign word_idx_s = addr_i[ADDR_W-1:2];
  assign mem_idx_s  = word_idx_s[MEM_AW-1:0];
  assign in_range_s = (word_idx_s < DEPTH_IDX);
  assign unused_s   = ^addr_i[1:0];

  // Full blocks the grant even if the head pops on the same edge.
  assign gnt_o      = req_i & ~gnt_stall_i & ~rst_i & (outst_r < CNT_FULL);
  assign accept_s   = req_i & gnt_o;
  assign empty_s    = (outst_r == {CNT_W{1'b0}});
  assign head_rdy_s = ~empty_s & (q_age_r[rd_ptr_r] == AGE_RDY);
  assign pop_s      = head_rdy_s & ~resp_stall_i;

  // Response payload for the transaction being accepted this cycle
  always_comb begin
    push_data_s = 32'h0;
    push_err_s  = 1'b0;
    if (!in_range_s) begin
      push_err_s = 1'b1;
    end else if (!we_i) begin
      push_data_s = mem_r[mem_idx_s];
    end else begin
      push_data_s = 32'h0;
    end
  end

  // Byte-enabled memory write; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (accept_s && we_i && in_range_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_r[mem_idx_s][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Queue payload and per-slot age; validity is carried by the pointers and count
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (accept_s && (wr_ptr_r == PTR_W'(i))) begin
        q_data_r[i] <= push_data_s;
        q_err_r[i]  <= push_err_s;
        q_age_r[i]  <= {AGE_W{1'b0}};
      end else if (q_age_r[i] != AGE_RDY) begin
        q_age_r[i]  <= q_age_r[i] + AGE_W'(1);
      end
    end
  end

  // Queue pointers, outstanding count and registered response outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      outst_r  <= {CNT_W{1'b0}};
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0;
      err_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({accept_s, pop_s})
        2'b10:   outst_r <= outst_r + CNT_W'(1);
        2'b01:   outst_r <= outst_r - CNT_W'(1);
        default: outst_r <= outst_r;
      endcase
      rvalid_r <= pop_s;
      rdata_r  <= pop_s ? q_data_r[rd_ptr_r] : 32'h0;
      err_r    <= pop_s & q_err_r[rd_ptr_r];
    end
  end

  assign rvalid_o = rvalid_r;
  assign rdata_o  = rdata_r;
  assign err_o    = err_r;
  assign outst_o  = outst_r;

  obi_data_responder_chk #(
    .RESP_LAT  (RESP_LAT),
    .MAX_OUTST (MAX_OUTST)
  ) u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .outst_i (outst_r),
    .pop_i   (pop_s),
    .empty_i (empty_s)
  );
endmodule
